timer_device: RTL
=================

Name: timer_device

Overview:
- Memory-mapped programmable down-counter timer. It is the responder on the CPU's external device bus: CPU address, write data, write enable and read data.
- Decodes its 16-byte window and serves register reads and writes from the MEM stage.
- Raises an interrupt line that the top level wires into one bit of the CPU's HWInt[5:0].
- Sits beside the data memory behind the address decode, on the same clock as the pipeline.

Parameters:
- BASE_ADDR, 32'h0000_7F00, word-aligned base of the 16-byte register window; only BASE_ADDR[31:4] is compared.
- CNT_W, 32, width of PRESET/COUNT; must be ≤ 32, upper read bits zero-filled.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- DEV_Addr  in  32  byte address from the CPU MEM stage.
- DEV_WD  in  32  write data.
- DEV_WE  in  1  write strobe, already gated by the CPU's exception flush.
- DEV_RD  out  32  read data, combinational from DEV_Addr.
- IRQ  out  1  interrupt request to HWInt.

Behaviour:
- Address decode:
  - hit = (DEV_Addr[31:4]==BASE_ADDR[31:4]).
  - Offset DEV_Addr[3:2] selects the register: 0 CTRL, 1 PRESET, 2 COUNT (read-only), 3 reserved.
  - DEV_Addr[1:0] is ignored.
  - Miss: DEV_RD=0, writes ignored.
- CTRL fields: bit0 EN, bits2:1 MODE (0 one-shot, 1 auto-reload, 2/3 behave as 0), bit3 IM (interrupt mask). Bits 31:4 read 0.
- Read latency: zero. DEV_RD reflects current register values in the same cycle; the CPU captures it into its MEM/WB register.
- Writes occur on the rising edge when DEV_WE & hit. Writes to COUNT or the reserved offset are ignored.
- Reset values: CTRL=0, PRESET=0, COUNT=0, state IDLE, irq_flag=0, IRQ=0. DEV_RD=0 for any address while in reset.
- FSM transitions on each edge:
  - IDLE: EN → LOAD; otherwise stay.
  - LOAD: COUNT←PRESET → CNT.
  - CNT: !EN → IDLE with COUNT held. Else if COUNT≤1 → COUNT←0 and go to INT, setting irq_flag on the same edge. Else COUNT←COUNT-1.
  - INT, MODE 0: clear EN → IDLE; irq_flag stays set (sticky).
  - INT, MODE 1: → LOAD; irq_flag clears on leaving INT, so it is a single-cycle pulse.
- Timing and outputs:
  - IRQ = irq_flag & IM.
  - One-shot: IRQ rises PRESET+2 edges after the edge that writes EN=1 (PRESET ≥ 1).
  - Auto-reload period: PRESET+2 cycles.
  - PRESET=0 behaves as PRESET=1.
- Clearing the sticky flag: any CPU write to CTRL or PRESET clears irq_flag.
- Simultaneous events:
  - A CPU write to CTRL takes priority over the FSM's EN clear in INT.
  - A PRESET write during CNT affects only the next LOAD.
  - A CTRL write with EN=0 during CNT freezes COUNT and returns to IDLE on the next edge.
  - A CPU write on the same edge that the FSM sets irq_flag: the flag set wins.
- Reset asserted mid-count returns everything to reset values asynchronously, with no residual IRQ.

Optional Feature:
- Macro TIMER_PRESCALE_EN.
- Defined:
  - Offset 3 becomes PRESCALE (16 bits, reset 0, read/write).
  - In CNT, COUNT decrements only when the prescale tick fires, i.e. once every PRESCALE+1 cycles. The tick counter restarts in LOAD.
  - One-shot latency becomes 2 + PRESET·(PRESCALE+1) edges.
- Undefined: offset 3 reads 0, writes are ignored, and the block behaves as if PRESCALE=0.

Decomposition:
- Package timer_pkg holds:
  - state encoding (IDLE, LOAD, CNT, INT);
  - offset constants OFF_CTRL=2'd0, OFF_PRESET=2'd1, OFF_COUNT=2'd2, OFF_PRESCALE=2'd3;
  - CTRL bit positions and MODE encodings.
- One natural sub-module: timer_prescaler, a tick generator instantiated only under TIMER_PRESCALE_EN. Inputs clk, reset, restart, div; output tick.

Test Plan:
- One-shot: write PRESET=3, then CTRL=0x9 → IRQ rises 5 edges after the CTRL write edge, COUNT reads 0, CTRL reads 0x8 (EN cleared). IRQ stays high until a CTRL write of 0x0, and is low the cycle after that write.
- Auto-reload: PRESET=2, CTRL=0xB → IRQ is a one-cycle pulse every 4 cycles over 5 periods. COUNT reads 2, 1, 0 in sequence.
- Masking and decode: CTRL=0x1 with PRESET=1 → IRQ never rises, but the internal flag is set. Read BASE_ADDR+0xC → 0 (macro off). Write to BASE_ADDR+0x10 → no register changes.
- Pause: during CNT at COUNT=5, write CTRL=0x8 → COUNT frozen at 5 for 10 cycles. Rewrite CTRL=0x9 → reload from PRESET and restart.
- Async reset mid-count: assert reset between edges at COUNT=7 → DEV_RD, COUNT and IRQ go to 0 before the next edge. After release, the state stays IDLE.
- TIMER_PRESCALE_EN: PRESCALE=1, PRESET=3, CTRL=0x9 → IRQ rises 8 edges after the CTRL write edge.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped down-counter timer: FSM states,
// register offsets and CTRL field layout.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  localparam logic [1:0] OFF_CTRL     = 2'd0;
  localparam logic [1:0] OFF_PRESET   = 2'd1;
  localparam logic [1:0] OFF_COUNT    = 2'd2;
  localparam logic [1:0] OFF_PRESCALE = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  // Modes 2 and 3 fall back to one-shot behaviour.
  function automatic logic is_reload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Tick generator for the optional prescaler: tick fires once every div+1
// cycles, phase restarted by the restart strobe.
module timer_prescaler (
  input  logic        clk,
  input  logic        reset,
  input  logic        restart,
  input  logic [15:0] div,
  output logic        tick
);

  logic [15:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 16'd0;
    end else if (restart || r_cnt == 16'd0) begin
      r_cnt <= div;
    end else begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

  assign tick = (r_cnt == 16'd0);

endmodule

// File: rtl/timer_device.sv
// Memory-mapped programmable down-counter timer with interrupt output.
// Optional prescaler at offset 3 is enabled by defining TIMER_PRESCALE_EN.
//
// state | meaning
// IDLE  | waiting for CTRL.EN
// LOAD  | COUNT <= PRESET
// CNT   | counting down (on prescale tick)
// INT   | terminal count reached, irq_flag set
module timer_device
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter int          CNT_W     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] DEV_Addr,
  input  logic [31:0] DEV_WD,
  input  logic        DEV_WE,
  output logic [31:0] DEV_RD,
  output logic        IRQ
);

  state_t             r_state;
  logic               r_en;
  logic [1:0]         r_mode;
  logic               r_im;
  logic [CNT_W-1:0]   r_preset;
  logic [CNT_W-1:0]   r_count;
  logic               r_irq_flag;

  logic               w_hit;
  logic [1:0]         w_off;
  logic               w_wr_ctrl;
  logic               w_wr_preset;
  logic               w_freeze;
  logic               w_tick;
  logic               w_set_flag;
  logic [31:0]        w_rd;
  logic [1:0]         w_unused_addr;

  assign w_hit         = (DEV_Addr[31:4] == BASE_ADDR[31:4]);
  assign w_off         = DEV_Addr[3:2];
  assign w_unused_addr = DEV_Addr[1:0];
  assign w_wr_ctrl     = DEV_WE && w_hit && (w_off == OFF_CTRL);
  assign w_wr_preset   = DEV_WE && w_hit && (w_off == OFF_PRESET);
  // A CTRL write that drops EN stops the count on the very edge it lands.
  assign w_freeze      = w_wr_ctrl && !DEV_WD[CTRL_EN];
  assign w_set_flag    = (r_state == CNT) && r_en && !w_freeze && w_tick &&
                         (r_count <= CNT_W'(1));

`ifdef TIMER_PRESCALE_EN
  logic [15:0] r_prescale;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prescale <= 16'd0;
    end else if (DEV_WE && w_hit && (w_off == OFF_PRESCALE)) begin
      r_prescale <= DEV_WD[15:0];
    end
  end

  timer_prescaler u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .restart (r_state == LOAD),
    .div     (r_prescale),
    .tick    (w_tick)
  );
`else
  assign w_tick = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_en       <= 1'b0;
      r_mode     <= MODE_ONESHOT;
      r_im       <= 1'b0;
      r_preset   <= '0;
      r_count    <= '0;
      r_irq_flag <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_en   <= DEV_WD[CTRL_EN];
        r_mode <= DEV_WD[CTRL_MODE_HI:CTRL_MODE_LO];
        r_im   <= DEV_WD[CTRL_IM];
      end
      if (w_wr_preset) begin
        r_preset <= DEV_WD[CNT_W-1:0];
      end

      case (r_state)
        IDLE: begin
          if (r_en) r_state <= LOAD;
        end
        LOAD: begin
          r_count <= r_preset;
          r_state <= CNT;
        end
        CNT: begin
          if (!r_en) begin
            r_state <= IDLE;
          end else if (!w_freeze && w_tick) begin
            if (r_count <= CNT_W'(1)) begin
              r_count <= '0;
              r_state <= INT;
            end else begin
              r_count <= r_count - CNT_W'(1);
            end
          end
        end
        INT: begin
          if (is_reload(r_mode)) begin
            r_state <= LOAD;
          end else begin
            if (!w_wr_ctrl) r_en <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Flag set beats a clearing write on the same edge.
      if (w_set_flag) begin
        r_irq_flag <= 1'b1;
      end else if (w_wr_ctrl || w_wr_preset) begin
        r_irq_flag <= 1'b0;
      end else if (r_state == INT && is_reload(r_mode)) begin
        r_irq_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rd = '0;
    if (!reset && w_hit) begin
      case (w_off)
        OFF_CTRL:   w_rd = {28'd0, r_im, r_mode, r_en};
        OFF_PRESET: w_rd = 32'(r_preset);
        OFF_COUNT:  w_rd = 32'(r_count);
`ifdef TIMER_PRESCALE_EN
        default:    w_rd = {16'd0, r_prescale};
`else
        default:    w_rd = '0;
`endif
      endcase
    end
  end

  assign DEV_RD = w_rd;
  assign IRQ    = r_irq_flag & r_im;

endmodule
